// File: rtl/axi_lite_master_port_if.sv
// Purpose: bundles the core request/response side and the five AXI4-Lite
//          channels of axi_lite_master_port into one interface.
// Ports:   master modport = port view (drives AXI address/data/valids,
//          core responses); slave modport = core + AXI slave view.
interface axi_lite_master_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // core request / response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [1:0]            resp_code;

  // AR / R
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_arvalid;
  logic [2:0]            axi_arprot;
  logic                  axi_arready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  // AW / W / B
  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic                  axi_awvalid;
  logic [2:0]            axi_awprot;
  logic                  axi_awready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_WIDTH-1:0] axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;

  // status
  logic [CNT_WIDTH-1:0]  txn_count;
  logic [2:0]            debug_state;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_code,
    output axi_araddr, axi_arvalid, axi_arprot, input axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid, output axi_rready,
    output axi_awaddr, axi_awvalid, axi_awprot, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
    input  axi_bresp, axi_bvalid, output axi_bready,
    output txn_count, debug_state
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_code,
    input  axi_araddr, axi_arvalid, axi_arprot, output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid, input axi_rready,
    input  axi_awaddr, axi_awvalid, axi_awprot, output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
    output axi_bresp, axi_bvalid, input axi_bready,
    input  txn_count, debug_state
  );
endinterface

// File: rtl/axi_lite_master_port.sv
// Purpose: turns single-beat core load/store requests into AXI4-Lite reads or
//          writes; misaligned requests complete with code 01 and no bus traffic.
// Latency: zero-wait slave gives accept N, valid N+1, data/resp N+2, resp_valid N+3.
// Backpressure: one transaction at a time; req_ready only in IDLE, every AXI
//          valid is held until its ready. All AXI outputs are registered.
// Ports: clk, rst (sync, active-high); bus = axi_lite_master_port_if.master.
module axi_lite_master_port #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000,
  parameter int         CNT_WIDTH  = 16
) (
  input logic                    clk,
  input logic                    rst,
  axi_lite_master_port_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(STRB_WIDTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            code_q,    code_d;
  logic                  err_q,     err_d;
  logic [CNT_WIDTH-1:0]  count_q,   count_d;

  // OKAY and EXOKAY both count as success; SLVERR/DECERR pass through.
  function automatic logic [1:0] map_resp(input logic [1:0] r);
    return r[1] ? r : 2'b00;
  endfunction

  logic misaligned;
  logic ar_hs, aw_hs, w_hs;
  logic aw_now, w_now;

  assign misaligned = |bus.req_addr[ALIGN_BITS-1:0];
  assign ar_hs      = arvalid_q & bus.axi_arready;
  assign aw_hs      = awvalid_q & bus.axi_awready;
  assign w_hs       = wvalid_q  & bus.axi_wready;
  // A channel counts as done if it finished earlier or finishes this cycle.
  assign aw_now     = aw_done_q | aw_hs;
  assign w_now      = w_done_q  | w_hs;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    code_d    = code_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (misaligned) begin
            code_d  = 2'b01;
            state_d = S_RESP;
          end else if (bus.req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.axi_rvalid) begin
          rdata_d  = bus.axi_rdata;
          code_d   = map_resp(bus.axi_rresp);
          rready_d = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_WR_REQ: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.axi_bvalid) begin
          code_d   = map_resp(bus.axi_bresp);
          bready_d = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        count_d = count_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = (code_d != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      code_q    <= 2'b00;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      code_q    <= code_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.resp_code   = code_q;
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_arprot  = PROT;
  assign bus.axi_rready  = rready_q;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awprot  = PROT;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_bready  = bready_q;
  assign bus.txn_count   = count_q;
  assign bus.debug_state = state_q;
endmodule

// File: tb/tb_axi_lite_master_port.sv
module tb_axi_lite_master_port;
  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  axi_lite_master_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) ifa ();
  axi_lite_master_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CNT_WIDTH(2))  ifb ();

  axi_lite_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  axi_lite_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .PROT(3'b010), .CNT_WIDTH(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.req_valid = 0; ifa.req_we = 0; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.req_wstrb = '0;
    ifa.axi_arready = 0; ifa.axi_rdata = '0; ifa.axi_rresp = 0; ifa.axi_rvalid = 0;
    ifa.axi_awready = 0; ifa.axi_wready = 0; ifa.axi_bresp = 0; ifa.axi_bvalid = 0;
    ifb.req_valid = 0; ifb.req_we = 0; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.req_wstrb = '0;
    ifb.axi_arready = 0; ifb.axi_rdata = '0; ifb.axi_rresp = 0; ifb.axi_rvalid = 0;
    ifb.axi_awready = 0; ifb.axi_wready = 0; ifb.axi_bresp = 0; ifb.axi_bvalid = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_state",   ifa.debug_state, 0);
    chk("rst_req_rdy", ifa.req_ready, 1);
    chk("rst_arvalid", ifa.axi_arvalid, 0);
    chk("rst_awvalid", ifa.axi_awvalid, 0);
    chk("rst_wvalid",  ifa.axi_wvalid, 0);
    chk("rst_rready",  ifa.axi_rready, 0);
    chk("rst_bready",  ifa.axi_bready, 0);
    chk("rst_resp_v",  ifa.resp_valid, 0);
    chk("rst_err",     ifa.resp_err, 0);
    chk("rst_code",    ifa.resp_code, 0);
    chk("rst_rdata",   ifa.resp_rdata, 0);
    chk("rst_count",   ifa.txn_count, 0);
    chk("rst_araddr",  ifa.axi_araddr, 0);

    // aligned read, zero-wait slave
    ifa.axi_arready = 1; ifa.axi_rvalid = 1; ifa.axi_rdata = 32'hDEADBEEF; ifa.axi_rresp = 2'b00;
    ifa.req_valid = 1; ifa.req_we = 0; ifa.req_addr = 32'h0000_1004;
    tick();  // N+1
    ifa.req_valid = 0;
    chk("rd_arvalid",  ifa.axi_arvalid, 1);
    chk("rd_araddr",   ifa.axi_araddr, 32'h0000_1004);
    chk("rd_arprot",   ifa.axi_arprot, 3'b000);
    chk("rd_state1",   ifa.debug_state, 1);
    chk("rd_req_rdy",  ifa.req_ready, 0);
    chk("rd_resp_v1",  ifa.resp_valid, 0);
    tick();  // N+2
    chk("rd_state2",   ifa.debug_state, 2);
    chk("rd_rready",   ifa.axi_rready, 1);
    chk("rd_arvalid2", ifa.axi_arvalid, 0);
    tick();  // N+3
    chk("rd_resp_v3",  ifa.resp_valid, 1);
    chk("rd_rdata",    ifa.resp_rdata, 32'hDEADBEEF);
    chk("rd_err",      ifa.resp_err, 0);
    chk("rd_code",     ifa.resp_code, 0);
    chk("rd_rready3",  ifa.axi_rready, 0);
    ifa.axi_arready = 0; ifa.axi_rvalid = 0;
    tick();  // N+4
    chk("rd_resp_v4",  ifa.resp_valid, 0);
    chk("rd_count",    ifa.txn_count, 1);
    chk("rd_idle",     ifa.debug_state, 0);

    // write, W handshake three cycles before AW
    ifa.axi_wready = 1;
    ifa.req_valid = 1; ifa.req_we = 1; ifa.req_addr = 32'h2000;
    ifa.req_wdata = 32'h12345678; ifa.req_wstrb = 4'b0011;
    tick();  // N+1: W handshake happens here
    ifa.req_valid = 0;
    chk("wr_awvalid1", ifa.axi_awvalid, 1);
    chk("wr_wvalid1",  ifa.axi_wvalid, 1);
    chk("wr_awaddr",   ifa.axi_awaddr, 32'h2000);
    chk("wr_wdata",    ifa.axi_wdata, 32'h12345678);
    chk("wr_wstrb",    ifa.axi_wstrb, 4'b0011);
    chk("wr_state",    ifa.debug_state, 3);
    tick();  // N+2
    ifa.axi_wready = 0;
    chk("wr_wvalid2",  ifa.axi_wvalid, 0);
    chk("wr_awvalid2", ifa.axi_awvalid, 1);
    chk("wr_bready2",  ifa.axi_bready, 0);
    tick();  // N+3
    chk("wr_awvalid3", ifa.axi_awvalid, 1);
    chk("wr_bready3",  ifa.axi_bready, 0);
    tick();  // N+4: AW handshake
    ifa.axi_awready = 1;
    chk("wr_awvalid4", ifa.axi_awvalid, 1);
    chk("wr_wvalid4",  ifa.axi_wvalid, 0);
    tick();  // N+5
    ifa.axi_awready = 0;
    chk("wr_awvalid5", ifa.axi_awvalid, 0);
    chk("wr_bready5",  ifa.axi_bready, 1);
    chk("wr_state5",   ifa.debug_state, 4);
    ifa.axi_bvalid = 1; ifa.axi_bresp = 2'b00;
    tick();  // N+6
    chk("wr_resp_v",   ifa.resp_valid, 1);
    chk("wr_err",      ifa.resp_err, 0);
    chk("wr_code",     ifa.resp_code, 0);
    chk("wr_bready6",  ifa.axi_bready, 0);
    ifa.axi_bvalid = 0;
    tick();
    chk("wr_count",    ifa.txn_count, 2);

    // misaligned read: no AXI traffic, completes next cycle
    ifa.req_valid = 1; ifa.req_we = 0; ifa.req_addr = 32'h0000_1002;
    tick();
    ifa.req_valid = 0;
    chk("mis_state",   ifa.debug_state, 5);
    chk("mis_resp_v",  ifa.resp_valid, 1);
    chk("mis_code",    ifa.resp_code, 2'b01);
    chk("mis_err",     ifa.resp_err, 1);
    chk("mis_arvalid", ifa.axi_arvalid, 0);
    tick();
    chk("mis_arvalid2", ifa.axi_arvalid, 0);
    chk("mis_count",   ifa.txn_count, 3);

    // write with DECERR, zero-wait
    ifa.axi_awready = 1; ifa.axi_wready = 1;
    ifa.req_valid = 1; ifa.req_we = 1; ifa.req_addr = 32'h3000; ifa.req_wdata = 32'h1; ifa.req_wstrb = 4'hF;
    tick();  // N+1
    ifa.req_valid = 0;
    tick();  // N+2
    ifa.axi_awready = 0; ifa.axi_wready = 0;
    chk("dec_bready",  ifa.axi_bready, 1);
    chk("dec_awvalid", ifa.axi_awvalid, 0);
    chk("dec_wvalid",  ifa.axi_wvalid, 0);
    ifa.axi_bvalid = 1; ifa.axi_bresp = 2'b11;
    tick();  // N+3
    chk("dec_resp_v",  ifa.resp_valid, 1);
    chk("dec_code",    ifa.resp_code, 2'b11);
    chk("dec_err",     ifa.resp_err, 1);
    ifa.axi_bvalid = 0; ifa.axi_bresp = 2'b00;
    tick();
    chk("dec_count",   ifa.txn_count, 4);

    // read with SLVERR: data still captured
    ifa.axi_arready = 1; ifa.axi_rvalid = 1; ifa.axi_rdata = 32'hA5A5A5A5; ifa.axi_rresp = 2'b10;
    ifa.req_valid = 1; ifa.req_we = 0; ifa.req_addr = 32'h0000_4000;
    tick();
    ifa.req_valid = 0;
    tick();
    tick();
    chk("slv_resp_v",  ifa.resp_valid, 1);
    chk("slv_code",    ifa.resp_code, 2'b10);
    chk("slv_rdata",   ifa.resp_rdata, 32'hA5A5A5A5);
    chk("slv_err",     ifa.resp_err, 1);
    ifa.axi_arready = 0; ifa.axi_rvalid = 0; ifa.axi_rresp = 2'b00;
    tick();
    chk("slv_count",   ifa.txn_count, 5);

    // EXOKAY read maps to OK
    ifa.axi_arready = 1; ifa.axi_rvalid = 1; ifa.axi_rdata = 32'h0BAD_F00D; ifa.axi_rresp = 2'b01;
    ifa.req_valid = 1; ifa.req_addr = 32'h0000_5008;
    tick();
    ifa.req_valid = 0;
    tick();
    tick();
    chk("exo_code",    ifa.resp_code, 2'b00);
    chk("exo_err",     ifa.resp_err, 0);
    ifa.axi_arready = 0; ifa.axi_rvalid = 0; ifa.axi_rresp = 2'b00;
    tick();
    chk("exo_count",   ifa.txn_count, 6);

    // reset while waiting in RD_DATA
    ifa.axi_arready = 1;
    ifa.req_valid = 1; ifa.req_addr = 32'h0000_6000;
    tick();  // RD_ADDR
    ifa.req_valid = 0;
    tick();  // RD_DATA
    ifa.axi_arready = 0;
    chk("mid_state",   ifa.debug_state, 2);
    chk("mid_rready",  ifa.axi_rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", ifa.debug_state, 0);
    chk("mid_rst_rready", ifa.axi_rready, 0);
    chk("mid_rst_reqrdy", ifa.req_ready, 1);
    chk("mid_rst_count", ifa.txn_count, 0);
    chk("mid_rst_rdata", ifa.resp_rdata, 0);

    // 64-bit, 2-bit counter: back-to-back reads wrap the counter
    ifb.axi_arready = 1; ifb.axi_rvalid = 1;
    chk("b_rst_count", ifb.txn_count, 0);
    begin
      logic [1:0]  exp_cnt [5];
      logic [31:0] addrs   [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      addrs   = '{32'h08, 32'h10, 32'h18, 32'h20, 32'h28};
      for (int i = 0; i < 5; i++) begin
        ifb.axi_rdata = 64'hCAFE_0000_0000_0000 | 64'(i);
        ifb.req_valid = 1; ifb.req_we = 0; ifb.req_addr = addrs[i];
        tick();
        ifb.req_valid = 0;
        chk("b_araddr",  ifb.axi_araddr, addrs[i]);
        chk("b_arprot",  ifb.axi_arprot, 3'b010);
        tick();
        tick();
        chk("b_resp_v",  ifb.resp_valid, 1);
        chk("b_rdata",   ifb.resp_rdata, 64'hCAFE_0000_0000_0000 | 64'(i));
        tick();
        chk("b_count",   ifb.txn_count, exp_cnt[i]);
      end
    end
    ifb.axi_arready = 0; ifb.axi_rvalid = 0;
    ifb.req_valid = 1; ifb.req_addr = 32'h0C;
    tick();
    ifb.req_valid = 0;
    chk("b_mis_state", ifb.debug_state, 5);
    chk("b_mis_code",  ifb.resp_code, 2'b01);
    chk("b_mis_arv",   ifb.axi_arvalid, 0);
    tick();
    chk("b_mis_count", ifb.txn_count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_master_port.md
Name: axi_lite_master_port

Overview:
Parametrised AXI4-Lite master port that turns the core's single-beat load/store requests into AXI4-Lite read or write transactions toward the MMU bus. It generalises the core's fixed 32-bit AXI-Lite master interface in address/data width and protection bits. It adds behaviour the fixed interface lacks:
- independent AW/W handshakes
- misalignment rejection without bus traffic
- error response propagation
- a transaction counter

Parameters:
ADDR_WIDTH, 32, width of req_addr and axi_araddr/axi_awaddr.
DATA_WIDTH, 32, data width; must be 32 or 64. Strobe width STRB_WIDTH = DATA_WIDTH/8.
PROT, 3'b000, constant driven on axi_arprot/axi_awprot.
CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  port can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB_WIDTH  write byte enables
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  read data; held until next resp_valid
resp_err  out  1  completion carried an error; qualified by resp_valid
resp_code  out  2  00 OK, 01 misaligned, 10 SLVERR, 11 DECERR
axi_araddr/axi_arvalid/axi_arprot/axi_arready  AR channel (out/out/out 3/in)
axi_rdata/axi_rresp/axi_rvalid/axi_rready  R channel (in DATA_WIDTH/in 2/in/out)
axi_awaddr/axi_awvalid/axi_awprot/axi_awready  AW channel (out/out/out 3/in)
axi_wdata/axi_wstrb/axi_wvalid/axi_wready  W channel (out DATA_WIDTH/out STRB_WIDTH/out/in)
axi_bresp/axi_bvalid/axi_bready  B channel (in 2/in/out)
txn_count  out  CNT_WIDTH  number of completed transactions
debug_state  out  3  current state encoding

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; every valid/ready output 0 except req_ready=1; resp_err=0; resp_code=0; resp_rdata=0; txn_count=0; address/data outputs 0.
- State encodings: IDLE=0, RD_ADDR=1, RD_DATA=2, WR_REQ=3, WR_RESP=4, RESP=5.
- req_ready = (state==IDLE). A request is accepted on a cycle where req_valid and req_ready are both 1. The address, data and strobes are registered on acceptance.
- Alignment: an address is misaligned if the low log2(STRB_WIDTH) address bits are non-zero.
- IDLE, misaligned request: go to RESP with resp_code=01. No AXI valid is ever raised.
- IDLE, aligned read: go to RD_ADDR. axi_arvalid=1 from the next cycle.
- IDLE, aligned write: go to WR_REQ. axi_awvalid=1 and axi_wvalid=1 from the next cycle.
- RD_ADDR: hold axi_arvalid and axi_araddr stable until axi_arready. On that handshake, drop arvalid, set axi_rready=1, go to RD_DATA.
- RD_DATA: on axi_rvalid, capture rdata and rresp, drop rready, go to RESP.
- WR_REQ: AW and W complete independently, tracked by aw_done/w_done flags.
  - Each valid drops on the cycle after its own handshake.
  - Both handshakes may occur in the same cycle, or in either order.
  - When both are done, set axi_bready=1 and go to WR_RESP.
- WR_RESP: on axi_bvalid, capture bresp, drop bready, go to RESP.
- RESP (exactly one cycle):
  - resp_valid=1; resp_err=(resp_code!=00); txn_count increments, wrapping at 2^CNT_WIDTH.
  - Next state is IDLE. A new request is accepted no earlier than the cycle after RESP.
- Response mapping: rresp/bresp 00 and 01 (OKAY/EXOKAY) map to code 00; 10 maps to 10; 11 maps to 11. On a read error, resp_rdata still takes axi_rdata.
- Minimum latency, zero-wait slave: read is accept at N, arvalid at N+1, rvalid&rready at N+2, resp_valid at N+3. Write is the same.
- All AXI outputs come from registers. None depends combinationally on an AXI input.
- Reset mid-transaction returns to IDLE and clears all valids the next edge. The port does not track the abandoned transaction; this is the system's responsibility.
- The port never issues a new address while any response is outstanding.

Test Plan:
- Aligned read at 0x0000_1004, slave ready immediately, rdata=0xDEADBEEF, rresp=00 -> resp_valid pulse at N+3, resp_rdata=0xDEADBEEF, resp_err=0, txn_count=1.
- Write to 0x2000, wdata=0x12345678, wstrb=4'b0011; slave gives wready 3 cycles before awready -> wvalid drops after its handshake while awvalid stays high; bready only after both handshakes; bresp=00 gives resp_err=0.
- Read at 0x0000_1002 (DATA_WIDTH=32) -> no arvalid ever; resp_valid the cycle after acceptance with resp_code=01 and resp_err=1; txn_count increments.
- Write with bresp=2'b11 -> resp_code=11, resp_err=1. Read with rresp=2'b10 and rdata=0xA5A5A5A5 -> resp_code=10, resp_rdata=0xA5A5A5A5.
- rst asserted while in RD_DATA with rvalid low -> next cycle state=0, axi_rready=0, req_ready=1, txn_count=0.
- DATA_WIDTH=64, CNT_WIDTH=2: five back-to-back aligned reads at 0x8, 0x10, 0x18, 0x20, 0x28 -> txn_count sequence 1, 2, 3, 0, 1. Address 0x0C is flagged misaligned.
